// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the data-memory load/store interface.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0010_0000;

  // Word index of a byte address relative to the segment base, in 32 bits.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM with a per-byte write mask.
module data_mem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // One access per enabled cycle: masked write, or registered read that holds otherwise.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, fixed-latency response out.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic          r_rd_ok;

  logic          w_accept;
  logic          w_go_resp;
  logic          w_op_write;
  logic [31:0]   w_op_addr;
  logic [31:0]   w_op_wdata;
  logic [3:0]    w_op_be;
  logic [31:0]   w_idx;
  logic          w_op_err;
  logic [31:0]   w_ram_rdata;

  // The RAM access happens on the edge entering RESP; with LATENCY=1 that is the
  // acceptance edge itself, so the operands come straight from the request then.
  always_comb begin
    w_accept   = (r_state == IDLE) && r_req_ready && req_valid;
    w_go_resp  = ((LATENCY == 1) && w_accept) || ((r_state == WAIT) && (r_cnt == '0));
    w_op_write = (r_state == IDLE) ? req_write : r_write;
    w_op_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    w_op_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    w_op_be    = (r_state == IDLE) ? req_be    : r_be;
    w_idx      = word_index(w_op_addr, BASE_ADDR);
    w_op_err   = (w_op_addr[1:0] != 2'b00) || (w_op_addr < BASE_ADDR) ||
                 (w_idx >= 32'(DEPTH_WORDS));
  end

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_en    (w_go_resp && !w_op_err),
    .i_we    (w_op_write),
    .i_be    (w_op_be),
    .i_addr  (w_idx[AW-1:0]),
    .i_wdata (w_op_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Transaction FSM: accept, count down the latency, hold the response until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rd_ok     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_be        <= req_be;
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
            r_cnt       <= CW'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_ok     <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
      // Entering RESP overrides the WAIT transition for the LATENCY=1 case.
      if (w_go_resp) begin
        r_state     <= RESP;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_op_err;
        r_rd_ok     <= !w_op_write && !w_op_err;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  // Read data is gated by a registered qualifier so stores, errors and reset show zero.
  assign rsp_rdata = r_rd_ok ? w_ram_rdata : '0;

endmodule
